// File: rtl/instr_decode_pipe_if.sv
// Fetch-to-decode and decode-to-regread handshake bundle for instr_decode_pipe.
// Optional out_illegal is present only when DECODE_ILLEGAL_TRAP_EN is defined.
interface instr_decode_pipe_if #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 16,
  parameter int NUM_REGS = 8
);
  localparam int REG_AW = $clog2(NUM_REGS);

  logic              in_valid;
  logic              in_ready;
  logic [15:0]       in_instr;
  logic [ADDR_W-1:0] in_pc;

  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_pc;
  logic [1:0]        out_cls;
  logic [4:0]        out_alu_op;
  logic [REG_AW-1:0] out_ra;
  logic [REG_AW-1:0] out_rb;
  logic [REG_AW-1:0] out_rc;
  logic [DATA_W-1:0] out_imm;
  logic              out_rf_we;
  logic              out_mem_rd;
  logic              out_mem_wr;
  logic              out_uop_last;
`ifdef DECODE_ILLEGAL_TRAP_EN
  logic              out_illegal;
`endif

  // Fetch buffer / register-read side
  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_cls, out_alu_op, out_ra, out_rb, out_rc, out_imm,
`ifdef DECODE_ILLEGAL_TRAP_EN
    input  out_illegal,
`endif
    input  out_rf_we, out_mem_rd, out_mem_wr, out_uop_last
  );

  // Decoder side
  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_cls, out_alu_op, out_ra, out_rb, out_rc, out_imm,
`ifdef DECODE_ILLEGAL_TRAP_EN
    output out_illegal,
`endif
    output out_rf_we, out_mem_rd, out_mem_wr, out_uop_last
  );
endinterface

// File: rtl/instr_decode_pipe.sv
// IITB-RISC decode stage with valid/ready handshake, flush, and LM/SM
// expansion into one micro-op per set mask bit (lowest bit first).
// Optional illegal-opcode flag: define DECODE_ILLEGAL_TRAP_EN.
module instr_decode_pipe #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 16,
  parameter int NUM_REGS = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  instr_decode_pipe_if.slave bus
);
  localparam int REG_AW = $clog2(NUM_REGS);
  localparam int CNT_W  = $clog2(NUM_REGS + 1);

  typedef enum logic {IDLE = 1'b0, MULTI = 1'b1} state_e;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] pc;
    logic [1:0]        cls;
    logic [4:0]        alu_op;
    logic [REG_AW-1:0] ra;
    logic [REG_AW-1:0] rb;
    logic [REG_AW-1:0] rc;
    logic [DATA_W-1:0] imm;
    logic              rf_we;
    logic              mem_rd;
    logic              mem_wr;
    logic              last;
`ifdef DECODE_ILLEGAL_TRAP_EN
    logic              illegal;
`endif
  } uop_t;

  state_e              state_q, state_d;
  uop_t                uop_q, uop_d;
  logic [NUM_REGS-1:0] mask_q, mask_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [REG_AW-1:0]   base_q, base_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic                lm_q, lm_d;

  logic [15:0]         instr;
  logic [3:0]          opc;
  logic [DATA_W-1:0]   sx6, sx9, lhi;
  logic [NUM_REGS-1:0] in_mask;
  uop_t                dec, ms_uop;
  logic                is_ms, advance, in_ready, take;

  logic [NUM_REGS-1:0] ms_mask, ms_rem;
  logic [CNT_W-1:0]    ms_cnt;
  logic [REG_AW-1:0]   ms_base, ms_k;
  logic [ADDR_W-1:0]   ms_pc;
  logic                ms_lm;

  function automatic logic [REG_AW-1:0] low_bit(input logic [NUM_REGS-1:0] m);
    low_bit = '0;
    for (int i = NUM_REGS - 1; i >= 0; i--)
      if (m[i]) low_bit = REG_AW'(i);
  endfunction

  assign instr   = bus.in_instr;
  assign opc     = instr[15:12];
  assign sx6     = DATA_W'($signed(instr[5:0]));
  assign sx9     = DATA_W'($signed(instr[8:0]));
  assign lhi     = DATA_W'({instr[8:0], 7'b0});
  assign in_mask = instr[NUM_REGS-1:0];

  // Single-instruction decode; LM/SM here is the empty-mask NOP form
  always_comb begin
    dec       = '0;
    dec.valid = 1'b1;
    dec.pc    = bus.in_pc;
    dec.ra    = REG_AW'(instr[11:9]);
    dec.rb    = REG_AW'(instr[8:6]);
    dec.rc    = REG_AW'(instr[5:3]);
    dec.last  = 1'b1;
    is_ms     = 1'b0;
    case (opc)
      4'h0: begin dec.cls = 2'b10; dec.alu_op = 5'b00000; dec.imm = sx6; dec.rf_we = 1'b1; end
      4'h1: begin dec.cls = 2'b11; dec.alu_op = {instr[1:0], 3'b000}; dec.rf_we = 1'b1; end
      4'h2: begin dec.cls = 2'b11; dec.alu_op = {instr[1:0], 3'b001}; dec.rf_we = 1'b1; end
      4'h3: begin dec.cls = 2'b01; dec.alu_op = 5'b00010; dec.imm = lhi; dec.rf_we = 1'b1; end
      4'h4: begin
        dec.cls = 2'b10; dec.alu_op = 5'b00011; dec.imm = sx6;
        dec.rf_we = 1'b1; dec.mem_rd = 1'b1;
      end
      4'h5: begin dec.cls = 2'b10; dec.alu_op = 5'b00011; dec.imm = sx6; dec.mem_wr = 1'b1; end
      4'h6, 4'h7: begin dec.alu_op = 5'b00111; is_ms = 1'b1; end
      4'h8: begin dec.cls = 2'b10; dec.alu_op = 5'b00100; dec.imm = sx6; end
      4'h9: begin dec.cls = 2'b01; dec.alu_op = 5'b00101; dec.imm = sx9; dec.rf_we = 1'b1; end
      4'hA: begin dec.cls = 2'b10; dec.alu_op = 5'b00101; dec.rf_we = 1'b1; end
      4'hB: begin dec.cls = 2'b01; dec.alu_op = 5'b00101; dec.imm = sx9; end
      default: begin
        dec.alu_op = 5'b00111;
`ifdef DECODE_ILLEGAL_TRAP_EN
        dec.illegal = 1'b1;
`endif
      end
    endcase
  end

  // LM/SM micro-op builder: fresh instruction in IDLE, saved context in MULTI
  always_comb begin
    if (state_q == MULTI) begin
      ms_mask = mask_q; ms_cnt = cnt_q; ms_base = base_q; ms_pc = pc_q; ms_lm = lm_q;
    end else begin
      ms_mask = in_mask; ms_cnt = '0; ms_base = dec.ra; ms_pc = bus.in_pc; ms_lm = ~opc[0];
    end
    ms_k          = low_bit(ms_mask);
    ms_rem        = ms_mask & ~(NUM_REGS'(1) << ms_k);
    ms_uop        = '0;
    ms_uop.valid  = 1'b1;
    ms_uop.pc     = ms_pc;
    ms_uop.cls    = 2'b01;
    ms_uop.alu_op = 5'b00011;
    ms_uop.ra     = ms_base;
    ms_uop.imm    = DATA_W'(ms_cnt);
    ms_uop.last   = (ms_rem == '0);
    if (ms_lm) begin
      ms_uop.rc = ms_k; ms_uop.rf_we = 1'b1; ms_uop.mem_rd = 1'b1;
    end else begin
      ms_uop.rb = ms_k; ms_uop.mem_wr = 1'b1;
    end
  end

  assign advance = bus.out_ready | ~uop_q.valid;
  assign in_ready = (state_q == IDLE) & advance & ~flush & ~reset;
  assign take     = bus.in_valid & in_ready;

  // Next-state: flush kills everything, MULTI drains mask, IDLE accepts
  always_comb begin
    state_d = state_q; uop_d = uop_q; mask_d = mask_q; cnt_d = cnt_q;
    base_d  = base_q;  pc_d  = pc_q;  lm_d   = lm_q;
    if (flush) begin
      state_d = IDLE; uop_d = '0; mask_d = '0; cnt_d = '0;
    end else if (state_q == MULTI) begin
      if (advance) begin
        uop_d  = ms_uop;
        mask_d = ms_rem;
        cnt_d  = cnt_q + CNT_W'(1);
        if (ms_rem == '0) state_d = IDLE;
      end
    end else if (advance) begin
      if (take && is_ms && in_mask != '0) begin
        uop_d  = ms_uop;
        mask_d = ms_rem;
        cnt_d  = CNT_W'(1);
        base_d = dec.ra;
        pc_d   = bus.in_pc;
        lm_d   = ms_lm;
        if (ms_rem != '0) state_d = MULTI;
      end else if (take) begin
        uop_d = dec;
      end else begin
        uop_d = '0;
      end
    end
  end

  // State and output register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE; uop_q <= '0; mask_q <= '0; cnt_q <= '0;
      base_q  <= '0;   pc_q  <= '0; lm_q   <= 1'b0;
    end else begin
      state_q <= state_d; uop_q <= uop_d; mask_q <= mask_d; cnt_q <= cnt_d;
      base_q  <= base_d;  pc_q  <= pc_d;  lm_q   <= lm_d;
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = uop_q.valid;
  assign bus.out_pc       = uop_q.pc;
  assign bus.out_cls      = uop_q.cls;
  assign bus.out_alu_op   = uop_q.alu_op;
  assign bus.out_ra       = uop_q.ra;
  assign bus.out_rb       = uop_q.rb;
  assign bus.out_rc       = uop_q.rc;
  assign bus.out_imm      = uop_q.imm;
  assign bus.out_rf_we    = uop_q.rf_we;
  assign bus.out_mem_rd   = uop_q.mem_rd;
  assign bus.out_mem_wr   = uop_q.mem_wr;
  assign bus.out_uop_last = uop_q.last;
`ifdef DECODE_ILLEGAL_TRAP_EN
  assign bus.out_illegal  = uop_q.illegal;
`endif
endmodule

// File: tb/tb_instr_decode_pipe.sv
// Bench for instr_decode_pipe: directed spec scenarios then random traffic,
// checked against a queue-based instruction-expansion model.
module tb_instr_decode_pipe;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  instr_decode_pipe_if #(.DATA_W(16), .ADDR_W(16), .NUM_REGS(8)) bus ();

  instr_decode_pipe #(.DATA_W(16), .ADDR_W(16), .NUM_REGS(8)) dut (
    .clk(clk), .reset(reset), .flush(flush), .bus(bus)
  );

  typedef struct {
    logic [1:0]  cls;
    logic [4:0]  alu;
    logic [2:0]  ra, rb, rc;
    logic [15:0] imm, pc;
    logic        we, rd, wr, last, ill;
    bit          c_alu, c_rb, c_rc, c_imm;
  } exp_t;

  exp_t pend[$];
  exp_t cur;
  logic cur_v = 1'b0;
  logic exp_rdy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected micro-op list for one accepted instruction
  task automatic expand(input logic [15:0] i, input logic [15:0] pc);
    exp_t e, f;
    int   n, tot;
    e = '{default: '0};
    e.pc = pc; e.ra = i[11:9]; e.rb = i[8:6]; e.rc = i[5:3];
    e.last = 1'b1; e.c_alu = 1'b1; e.c_imm = 1'b1;
    case (i[15:12])
      4'h0: begin e.cls = 2; e.alu = 0; e.imm = {{10{i[5]}}, i[5:0]}; e.we = 1; e.c_rb = 1; end
      4'h1: begin e.cls = 3; e.alu = {i[1:0], 3'd0}; e.we = 1; e.c_rb = 1; e.c_rc = 1; end
      4'h2: begin e.cls = 3; e.alu = {i[1:0], 3'd1}; e.we = 1; e.c_rb = 1; e.c_rc = 1; end
      4'h3: begin e.cls = 1; e.alu = 2; e.imm = {i[8:0], 7'd0}; e.we = 1; end
      4'h4: begin e.cls = 2; e.alu = 3; e.imm = {{10{i[5]}}, i[5:0]}; e.we = 1; e.rd = 1; e.c_rb = 1; end
      4'h5: begin e.cls = 2; e.alu = 3; e.imm = {{10{i[5]}}, i[5:0]}; e.wr = 1; e.c_rb = 1; end
      4'h8: begin e.cls = 2; e.alu = 4; e.imm = {{10{i[5]}}, i[5:0]}; e.c_rb = 1; end
      4'h9: begin e.cls = 1; e.alu = 5; e.imm = {{7{i[8]}}, i[8:0]}; e.we = 1; end
      4'hA: begin e.cls = 2; e.alu = 5; e.imm = 0; e.we = 1; e.c_rb = 1; end
      4'hB: begin e.cls = 1; e.c_alu = 0; e.imm = {{7{i[8]}}, i[8:0]}; end
      4'h6, 4'h7: begin
        e.alu = 7; e.c_imm = 0;
        if (i[7:0] == 0) pend.push_back(e);
        else begin
          tot = $countones(i[7:0]); n = 0;
          for (int k = 0; k < 8; k++) if (i[k]) begin
            f = e; f.cls = 1; f.alu = 3; f.imm = 16'(n); f.c_imm = 1;
            f.last = (n == tot - 1);
            if (i[12] == 1'b0) begin f.rc = 3'(k); f.c_rc = 1; f.we = 1; f.rd = 1; end
            else               begin f.rb = 3'(k); f.c_rb = 1; f.wr = 1; end
            pend.push_back(f);
            n++;
          end
        end
      end
      default: begin e.alu = 7; e.ill = 1; e.c_imm = 0; end
    endcase
    if (i[15:12] != 4'h6 && i[15:12] != 4'h7) pend.push_back(e);
  endtask

  task automatic step(input logic v, input logic [15:0] ins, input logic [15:0] pc,
                      input logic ordy, input logic fl, input logic rst);
    @(negedge clk);
    reset = rst; flush = fl;
    bus.in_valid = v; bus.in_instr = ins; bus.in_pc = pc; bus.out_ready = ordy;
    exp_rdy = !rst && !fl && pend.size() == 0 && (!cur_v || ordy);
    #1 chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    @(posedge clk);
    if (rst || fl) begin
      cur_v = 1'b0; pend.delete();
    end else if (!cur_v || ordy) begin
      if (pend.size() != 0) begin cur = pend.pop_front(); cur_v = 1'b1; end
      else if (v && exp_rdy) begin expand(ins, pc); cur = pend.pop_front(); cur_v = 1'b1; end
      else cur_v = 1'b0;
    end
    #1;
    chk("out_valid", 32'(bus.out_valid), 32'(cur_v));
`ifdef DECODE_ILLEGAL_TRAP_EN
    chk("out_illegal", 32'(bus.out_illegal), 32'(cur_v && cur.ill));
`endif
    if (cur_v) begin
      chk("out_pc", 32'(bus.out_pc), 32'(cur.pc));
      chk("out_cls", 32'(bus.out_cls), 32'(cur.cls));
      chk("out_ra", 32'(bus.out_ra), 32'(cur.ra));
      chk("out_rf_we", 32'(bus.out_rf_we), 32'(cur.we));
      chk("out_mem_rd", 32'(bus.out_mem_rd), 32'(cur.rd));
      chk("out_mem_wr", 32'(bus.out_mem_wr), 32'(cur.wr));
      chk("out_uop_last", 32'(bus.out_uop_last), 32'(cur.last));
      if (cur.c_alu) chk("out_alu_op", 32'(bus.out_alu_op), 32'(cur.alu));
      if (cur.c_rb)  chk("out_rb", 32'(bus.out_rb), 32'(cur.rb));
      if (cur.c_rc)  chk("out_rc", 32'(bus.out_rc), 32'(cur.rc));
      if (cur.c_imm) chk("out_imm", 32'(bus.out_imm), 32'(cur.imm));
    end
  endtask

  initial begin
    logic [15:0] ri;
    logic [3:0]  ro;
    bus.in_valid = 0; bus.in_instr = 0; bus.in_pc = 0; bus.out_ready = 0;

    // reset for two cycles
    step(0, 16'h0, 16'h0, 1, 0, 1);
    step(0, 16'h0, 16'h0, 1, 0, 1);
    chk("rst_cls", 32'(bus.out_cls), 0);
    chk("rst_imm", 32'(bus.out_imm), 0);
    chk("rst_pc", 32'(bus.out_pc), 0);
    chk("rst_we", 32'(bus.out_rf_we), 0);
    chk("rst_last", 32'(bus.out_uop_last), 0);
    step(0, 16'h0, 16'h0, 1, 0, 0);

    // ADI with negative imm6
    step(1, 16'h0A3F, 16'h0100, 1, 0, 0);
    chk("adi_cls", 32'(bus.out_cls), 32'h2);
    chk("adi_imm", 32'(bus.out_imm), 32'hFFFF);
    chk("adi_alu", 32'(bus.out_alu_op), 32'h0);
    chk("adi_we", 32'(bus.out_rf_we), 32'h1);

    // LM mask 0x29 -> rc 0,3,5
    step(1, 16'h6A29, 16'h0102, 1, 0, 0);
    chk("lm0_rc", 32'(bus.out_rc), 0);
    step(0, 16'h0, 16'h0, 1, 0, 0);
    chk("lm1_rc", 32'(bus.out_rc), 3);
    chk("lm1_imm", 32'(bus.out_imm), 1);
    step(0, 16'h0, 16'h0, 1, 0, 0);
    chk("lm2_rc", 32'(bus.out_rc), 5);
    chk("lm2_last", 32'(bus.out_uop_last), 1);

    // ADD stalled behind a held micro-op, then accepted
    for (int c = 0; c < 4; c++) step(1, 16'h1298, 16'h0104, 0, 0, 0);
    step(1, 16'h1298, 16'h0104, 1, 0, 0);
    chk("add_cls", 32'(bus.out_cls), 32'h3);
    chk("add_ra", 32'(bus.out_ra), 1);
    chk("add_rc", 32'(bus.out_rc), 3);

    // SM mask 0xFF, flushed after the second micro-op
    step(1, 16'h7AFF, 16'h0106, 1, 0, 0);
    step(0, 16'h0, 16'h0, 1, 0, 0);
    chk("sm1_rb", 32'(bus.out_rb), 1);
    step(1, 16'h1298, 16'h0108, 1, 1, 0);
    chk("flush_valid", 32'(bus.out_valid), 0);
    step(0, 16'h0, 16'h0, 1, 0, 0);
    step(0, 16'h0, 16'h0, 1, 0, 0);

    // illegal opcode
    step(1, 16'hF000, 16'h010A, 1, 0, 0);
    chk("ill_cls", 32'(bus.out_cls), 0);
    chk("ill_we", 32'(bus.out_rf_we), 0);
`ifdef DECODE_ILLEGAL_TRAP_EN
    chk("ill_flag", 32'(bus.out_illegal), 1);
`endif

    // random traffic
    for (int n = 0; n < 400; n++) begin
      ro = 4'($urandom_range(0, 15));
      ri = {ro, 12'($urandom)};
      if ((ro == 4'h6 || ro == 4'h7) && $urandom_range(0, 7) == 0) ri[7:0] = 8'h00;
      step(($urandom_range(0, 9) < 7), ri, 16'($urandom),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
